// File: rtl/complex_matrix_addsub_stream.sv
// Streaming complex matrix adder/subtractor.
// Two lock-stepped operand streams carry LANES complex elements per beat.
// Each lane computes A+B or A-B per component with optional saturation.
// A single output register stage gives one cycle of latency. Frame
// boundaries come from an internal beat counter, and the input tlast
// flags are only checked against it.
module complex_matrix_addsub_stream #(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 16,
  parameter int LANES        = 4,
  parameter int SATURATE     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          op_sub,
  input  logic [LANES*ELEMENT_SIZE-1:0] s_axis_a_tdata,
  input  logic                          s_axis_a_tvalid,
  input  logic                          s_axis_a_tlast,
  input  logic                          s_axis_a_tuser,
  output logic                          s_axis_a_tready,
  input  logic [LANES*ELEMENT_SIZE-1:0] s_axis_b_tdata,
  input  logic                          s_axis_b_tvalid,
  input  logic                          s_axis_b_tlast,
  input  logic                          s_axis_b_tuser,
  output logic                          s_axis_b_tready,
  output logic [LANES*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [1:0]                    m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          sat_flag,
  output logic                          frame_err
);

  localparam int H     = ELEMENT_SIZE / 2;
  localparam int DW    = LANES * ELEMENT_SIZE;
  localparam int BEATS = (MAT_WIDTH * MAT_HEIGHT) / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Sign-extend both components to H+1 bits so the sum/difference is exact.
  function automatic logic [H:0] addsub_comp(input logic [H-1:0] x,
                                             input logic [H-1:0] y,
                                             input logic         sub);
    logic [H:0] xe;
    logic [H:0] ye;
    xe = {x[H-1], x};
    ye = {y[H-1], y};
    return sub ? (xe - ye) : (xe + ye);
  endfunction

  // Most negative value when the exact result went below range, else most positive.
  function automatic logic [H-1:0] clamp_value(input logic negative);
    return negative ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
  endfunction

  logic [CNT_W-1:0] cnt_reg;
  logic             op_latched_reg;
  logic [DW-1:0]    tdata_reg;
  logic             tvalid_reg;
  logic             tlast_reg;
  logic [1:0]       tuser_reg;
  logic             sat_reg;
  logic             frame_err_reg;

  logic             in_ready;
  logic             accept;
  logic             last_beat;
  logic             op_now;
  logic [DW-1:0]    lane_result;
  logic [LANES-1:0] lane_sat;

  // The output stage can take a new beat when it is empty or being drained;
  // never ready while reset is held.
  assign in_ready  = (~tvalid_reg | m_axis_tready) & reset_n;
  assign accept    = s_axis_a_tvalid & s_axis_b_tvalid & in_ready;
  assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));
  // The first beat of a matrix uses op_sub live; later beats reuse the latched copy.
  assign op_now    = (cnt_reg == '0) ? op_sub : op_latched_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LO = gi * ELEMENT_SIZE;
      logic [H:0] re_sum;
      logic [H:0] im_sum;
      logic       re_ovf;
      logic       im_ovf;

      assign re_sum = addsub_comp(s_axis_a_tdata[LO+H +: H], s_axis_b_tdata[LO+H +: H], op_now);
      assign im_sum = addsub_comp(s_axis_a_tdata[LO +: H], s_axis_b_tdata[LO +: H], op_now);

      // Overflow shows as disagreement between the guard bit and the H-bit sign.
      assign re_ovf = (SATURATE != 0) && (re_sum[H] != re_sum[H-1]);
      assign im_ovf = (SATURATE != 0) && (im_sum[H] != im_sum[H-1]);

      assign lane_result[LO+H +: H] = re_ovf ? clamp_value(re_sum[H]) : re_sum[H-1:0];
      assign lane_result[LO +: H]   = im_ovf ? clamp_value(im_sum[H]) : im_sum[H-1:0];
      assign lane_sat[gi]           = re_ovf | im_ovf;
    end
  endgenerate

  // Beat counter and per-matrix operation latch; reset drops any partial matrix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg        <= '0;
      op_latched_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
      if (cnt_reg == '0) begin
        op_latched_reg <= op_sub;
      end
    end
  end

  // Output register: load on accept, go empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tuser_reg  <= '0;
      sat_reg    <= 1'b0;
    end else if (accept) begin
      tdata_reg  <= lane_result;
      tvalid_reg <= 1'b1;
      tlast_reg  <= last_beat;
      tuser_reg  <= {s_axis_a_tuser, s_axis_b_tuser};
      sat_reg    <= |lane_sat;
    end else if (m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  // One-cycle pulse when either input tlast disagrees with the counter position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= accept & ((s_axis_a_tlast != last_beat) | (s_axis_b_tlast != last_beat));
    end
  end

  assign s_axis_a_tready = in_ready;
  assign s_axis_b_tready = in_ready;
  assign m_axis_tdata    = tdata_reg;
  assign m_axis_tvalid   = tvalid_reg;
  assign m_axis_tlast    = tlast_reg;
  assign m_axis_tuser    = tuser_reg;
  assign sat_flag        = sat_reg;
  assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_complex_matrix_addsub_stream.sv
// Directed bench for complex_matrix_addsub_stream: a saturating instance and
// a wrapping instance share all inputs; expected values are hand computed.
module tb_complex_matrix_addsub_stream;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          op_sub = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;
  logic          a_valid = 1'b0, a_last = 1'b0, a_user = 1'b0;
  logic          b_valid = 1'b0, b_last = 1'b0, b_user = 1'b0;
  logic          m_ready = 1'b1;

  logic          a_ready, b_ready, m_valid, m_last, sat_flag, frame_err;
  logic [DW-1:0] m_data;
  logic [1:0]    m_user;
  logic          w_a_ready, w_b_ready, w_valid, w_last, w_sat, w_frame_err;
  logic [DW-1:0] w_data;
  logic [1:0]    w_user;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  complex_matrix_addsub_stream dut (
    .clk(clk), .reset_n(reset_n), .op_sub(op_sub),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tlast(a_last),
    .s_axis_a_tuser(a_user), .s_axis_a_tready(a_ready),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tlast(b_last),
    .s_axis_b_tuser(b_user), .s_axis_b_tready(b_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tuser(m_user), .m_axis_tready(m_ready),
    .sat_flag(sat_flag), .frame_err(frame_err)
  );

  complex_matrix_addsub_stream #(.SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .op_sub(op_sub),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tlast(a_last),
    .s_axis_a_tuser(a_user), .s_axis_a_tready(w_a_ready),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tlast(b_last),
    .s_axis_b_tuser(b_user), .s_axis_b_tready(w_b_ready),
    .m_axis_tdata(w_data), .m_axis_tvalid(w_valid), .m_axis_tlast(w_last),
    .m_axis_tuser(w_user), .m_axis_tready(m_ready),
    .sat_flag(w_sat), .frame_err(w_frame_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic al, input logic bl, input logic au, input logic bu);
    a_data = a; b_data = b;
    a_last = al; b_last = bl;
    a_user = au; b_user = bu;
    a_valid = 1'b1; b_valid = 1'b1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0;
    a_last = 1'b0; b_last = 1'b0;
    a_user = 1'b0; b_user = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    m_ready = 1'b1;
    set_beat({4{16'h1111}}, {4{16'h2222}}, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    ctl = {m_valid, m_last, m_user, sat_flag, frame_err, a_ready | b_ready};
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000000", ctl);
    end
    n_cmp++;
    if (m_data !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", m_data);
    end
    idle();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({a_ready, b_ready, m_valid} !== 3'b110) begin
      n_err++; $display("FAIL reset_release: got %b want 110", {a_ready, b_ready, m_valid});
    end
  endtask

  task automatic test_lone_valid();
    a_data = {4{16'h0101}}; a_valid = 1'b1; b_valid = 1'b0;
    tick();
    a_valid = 1'b0; b_valid = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL lone_valid: got m_valid %b want 0", m_valid);
    end
  endtask

  task automatic test_add();
    logic [DW-1:0] a, b, exp_s, exp_w;
    op_sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a     = {16'(1 + i), 16'h0203, 16'h7F01, 16'h1005};
      b     = {16'h0001,   16'h0405, 16'h0101, 16'h20FE};
      exp_s = {16'(2 + i), 16'h0608, 16'h7F02, 16'h3003};
      exp_w = {16'(2 + i), 16'h0608, 16'h8002, 16'h3003};
      set_beat(a, b, i == 3, i == 3, 1'b0, 1'b0);
      tick();
      $display("add beat %0d: data %h last %b sat %b", i, m_data, m_last, sat_flag);
      n_cmp++;
      if ({m_valid, m_last, sat_flag} !== {1'b1, i == 3, 1'b1}) begin
        n_err++; $display("FAIL add_ctl beat %0d: got %b want %b", i,
                          {m_valid, m_last, sat_flag}, {1'b1, i == 3, 1'b1});
      end
      n_cmp++;
      if (m_data !== exp_s) begin
        n_err++; $display("FAIL add_data beat %0d: got %h want %h", i, m_data, exp_s);
      end
      n_cmp++;
      if ({w_data, w_sat} !== {exp_w, 1'b0}) begin
        n_err++; $display("FAIL add_wrap beat %0d: got %h/%b want %h/0", i, w_data, w_sat, exp_w);
      end
    end
    idle();
    tick();
    n_cmp++;
    if ({m_valid, m_data} !== {1'b0, exp_s}) begin
      n_err++; $display("FAIL add_idle: got valid %b data %h want 0 %h", m_valid, m_data, exp_s);
    end
  endtask

  task automatic test_sub_sat();
    op_sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat({4{16'h7F00}}, {4{16'h8000}}, i == 3, i == 3, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({m_data, sat_flag, m_last} !== {{4{16'h7F00}}, 1'b1, i == 3}) begin
        n_err++; $display("FAIL sub_sat beat %0d: got %h sat %b last %b want 7f00.. 1 %b",
                          i, m_data, sat_flag, m_last, i == 3);
      end
      n_cmp++;
      if ({w_data, w_sat} !== {{4{16'hFF00}}, 1'b0}) begin
        n_err++; $display("FAIL sub_wrap beat %0d: got %h sat %b want ff00.. 0", i, w_data, w_sat);
      end
    end
    idle();
    op_sub = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp0;
    exp0 = {4{16'h0101}};
    m_ready = 1'b1;
    set_beat('0, {4{16'h0101}}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    m_ready = 1'b0;
    set_beat({4{16'h0101}}, {4{16'h0101}}, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({m_valid, m_data, m_last, m_user, a_ready, b_ready} !==
          {1'b1, exp0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL bp_hold cycle %0d: got v%b %h l%b u%b rdy%b%b", k,
                          m_valid, m_data, m_last, m_user, a_ready, b_ready);
      end
    end
    m_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      logic au, bu;
      au = i[0]; bu = i[1];
      set_beat({4{16'(257 * i)}}, {4{16'h0101}}, i == 3, i == 3, au, bu);
      tick();
      $display("bp beat %0d: data %h user %b last %b", i, m_data, m_user, m_last);
      n_cmp++;
      if ({m_valid, m_data, m_last, m_user} !== {1'b1, {4{16'(257 * (i + 1))}}, i == 3, au, bu}) begin
        n_err++; $display("FAIL bp_beat %0d: got v%b %h l%b u%b", i, m_valid, m_data, m_last, m_user);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_op_toggle();
    for (int i = 0; i < 4; i++) begin
      op_sub = (i >= 2);
      set_beat({4{16'h0503}}, {4{16'h0201}}, i == 3, i == 3, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (m_data !== {4{16'h0704}}) begin
        n_err++; $display("FAIL toggle_m1 beat %0d: got %h want 0704..", i, m_data);
      end
    end
    for (int i = 0; i < 4; i++) begin
      op_sub = (i == 0);
      set_beat({4{16'h0503}}, {4{16'h0201}}, i == 3, i == 3, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (m_data !== {4{16'h0302}}) begin
        n_err++; $display("FAIL toggle_m2 beat %0d: got %h want 0302..", i, m_data);
      end
    end
    idle();
    op_sub = 1'b0;
    tick();
  endtask

  task automatic test_frame_err();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      set_beat({4{16'h0101}}, {4{16'h0101}}, (i == 1) || (i == 3), i == 3, 1'b0, 1'b0);
      tick();
      if (frame_err === 1'b1) pulses++;
      n_cmp++;
      if ({m_last, frame_err} !== {i == 3, i == 1}) begin
        n_err++; $display("FAIL frame_beat %0d: got last %b err %b want %b %b",
                          i, m_last, frame_err, i == 3, i == 1);
      end
    end
    idle();
    tick();
    if (frame_err === 1'b1) pulses++;
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL frame_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      set_beat({4{16'h0102}}, {4{16'h0304}}, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    idle();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_last, m_user, sat_flag, frame_err, a_ready, b_ready} !== '0) begin
      n_err++; $display("FAIL mid_reset: got v%b %h l%b u%b s%b e%b r%b%b", m_valid, m_data,
                        m_last, m_user, sat_flag, frame_err, a_ready, b_ready);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat({4{16'h0102}}, {4{16'h0304}}, i == 3, i == 3, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({m_valid, m_last, m_data} !== {1'b1, i == 3, {4{16'h0406}}}) begin
        n_err++; $display("FAIL post_reset beat %0d: got v%b l%b %h want 1 %b 0406..",
                          i, m_valid, m_last, m_data, i == 3);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lone_valid();
    test_add();
    test_sub_sat();
    test_backpressure();
    test_op_toggle();
    test_frame_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complex_matrix_addsub_stream.md
COMPLEX_MATRIX_ADDSUB_STREAM -- requirements
Module: complex_matrix_addsub_stream

Interface
REQ-001 SHALL have parameter MAT_WIDTH, default 4, meaning matrix columns.
REQ-002 SHALL have parameter MAT_HEIGHT, default 4, meaning matrix rows.
REQ-003 SHALL have parameter ELEMENT_SIZE, default 16, meaning bits per complex element: real in upper half, imaginary in lower half, each two's complement of H=ELEMENT_SIZE/2 bits.
REQ-004 SHALL have parameter LANES, default 4, meaning elements per beat; MAT_WIDTH*MAT_HEIGHT SHALL be divisible by LANES; BEATS=MAT_WIDTH*MAT_HEIGHT/LANES.
REQ-005 SHALL have parameter SATURATE, default 1, meaning 1 clamps results and 0 wraps them.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 op_sub  input  1  0 = A+B, 1 = A-B; sampled per matrix.
REQ-009 s_axis_a_tdata / s_axis_b_tdata  input  LANES*ELEMENT_SIZE  operand beats; lane k occupies bits [(k+1)*ELEMENT_SIZE-1 : k*ELEMENT_SIZE].
REQ-010 s_axis_a_tvalid, s_axis_a_tlast, s_axis_a_tuser, s_axis_b_tvalid, s_axis_b_tlast, s_axis_b_tuser  input  1 each  operand stream controls.
REQ-011 s_axis_a_tready, s_axis_b_tready  output  1 each  operand stream ready.
REQ-012 m_axis_tdata  output  LANES*ELEMENT_SIZE  result beat, same lane layout.
REQ-013 m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-014 m_axis_tuser  output  2  {a_tuser, b_tuser} of the originating beat.
REQ-015 sat_flag  output  1  any component of the current output beat was clamped; aligned with m_axis_tdata.
REQ-016 frame_err  output  1  one-cycle pulse on input tlast mismatch.

Function
REQ-017 in_ready SHALL be (!m_axis_tvalid | m_axis_tready) & reset_n; both s_axis_*_tready SHALL equal in_ready.
REQ-018 A beat SHALL be accepted only when a_tvalid & b_tvalid & in_ready; a lone valid SHALL not be consumed.
REQ-019 Latency SHALL be 1 cycle: the accepted beat's result, tlast, tuser and sat_flag SHALL appear registered with m_axis_tvalid=1 on the next cycle.
REQ-020 While m_axis_tvalid & !m_axis_tready, all m_axis_* outputs and sat_flag SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-021 When no beat is accepted and m_axis_tready=1, m_axis_tvalid SHALL fall to 0 next cycle; tdata SHALL hold its last value.
REQ-022 The beat counter SHALL run 0..BEATS-1, increment per accepted beat and wrap to 0 after BEATS-1.
REQ-023 m_axis_tlast SHALL be 1 exactly on the output beat accepted at counter value BEATS-1, derived from the counter, not from the input tlasts.
REQ-024 op_sub SHALL be used live on the beat at counter 0 and latched for beats 1..BEATS-1; changes mid-matrix SHALL take effect only at the next matrix.
REQ-025 Per lane and per component: result = a +/- b computed at H+1 bits; SATURATE=1 clamps to [-2^(H-1), 2^(H-1)-1] and sets sat_flag; SATURATE=0 truncates to H bits and sat_flag stays 0.
REQ-026 frame_err SHALL pulse for one cycle, the cycle after acceptance, if a_tlast or b_tlast differs from (counter==BEATS-1); the counter SHALL not resynchronise.
REQ-027 Simultaneous output drain and new accept SHALL replace the output register in the same cycle with no bubble.

Reset
REQ-028 While reset_n=0: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, sat_flag=0, frame_err=0, s_axis_*_tready=0, counter=0, latched op=0.
REQ-029 Reset asserted mid-matrix SHALL discard the partial matrix; the first beat accepted after release SHALL be counter 0.

Verification
REQ-030 Add, ELEMENT_SIZE=16, LANES=4, 4x4: lane0 a=0x1005, b=0x20FE -> 0x3003 one cycle after accept; tlast on 4th beat only.
REQ-031 Sub, SATURATE=1: a real 0x7F, b real 0x80 -> real 0x7F, sat_flag=1; the same stimulus with SATURATE=0 -> real 0xFF, sat_flag=0.
REQ-032 Output valid with m_axis_tready low for 3 cycles -> tdata, tlast and tuser stable, s_axis tready low, all 4 beats delivered in order.
REQ-033 op_sub toggled 0->1 at beat 2 -> beats 2-3 still add; the next matrix subtracts.
REQ-034 a_tlast asserted on beat 1 -> frame_err pulses once; m_axis_tlast is still on beat 3.
REQ-035 reset_n pulsed low after 2 beats -> all outputs 0; the next matrix asserts tlast after exactly 4 accepted beats.
